// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl shared types and encodings.
// State codes match the legacy defines.v values.
package pipeline_ctrl_pkg;

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_FLUSH  = 2'd1;
  localparam logic [1:0] ST_LSTALL = 2'd2;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  typedef struct packed {
    logic jump_en;
    logic stall_pc;
    logic stall_ifid;
    logic stall_idex;
    logic flush_ifid;
    logic flush_idex;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

  function automatic logic any_stall(ctrl_t c);
    return c.stall_pc | c.stall_ifid | c.stall_idex;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl hazard inputs and stage controls.
// master drives hazard info, slave is the unit.
interface pipeline_ctrl_if;

  logic        jump_en_i;
  logic [31:0] jump_addr_i;
  logic        ex_busy_i;
  logic        ext_hold_i;
  logic        idex_is_load_i;
  logic        idex_reg_wen_i;
  logic [4:0]  idex_rd_addr_i;
  logic [4:0]  id_rs1_addr_i;
  logic [4:0]  id_rs2_addr_i;
  logic        id_rs1_used_i;
  logic        id_rs2_used_i;

  logic        jump_en_o;
  logic [31:0] jump_addr_o;
  logic        stall_pc_o;
  logic        stall_ifid_o;
  logic        flush_ifid_o;
  logic        stall_idex_o;
  logic        flush_idex_o;

  modport master (
    output jump_en_i, jump_addr_i,
    output ex_busy_i, ext_hold_i,
    output idex_is_load_i, idex_reg_wen_i,
    output idex_rd_addr_i,
    output id_rs1_addr_i, id_rs2_addr_i,
    output id_rs1_used_i, id_rs2_used_i,
    input  jump_en_o, jump_addr_o,
    input  stall_pc_o, stall_ifid_o,
    input  flush_ifid_o,
    input  stall_idex_o, flush_idex_o
  );

  modport slave (
    input  jump_en_i, jump_addr_i,
    input  ex_busy_i, ext_hold_i,
    input  idex_is_load_i, idex_reg_wen_i,
    input  idex_rd_addr_i,
    input  id_rs1_addr_i, id_rs2_addr_i,
    input  id_rs1_used_i, id_rs2_used_i,
    output jump_en_o, jump_addr_o,
    output stall_pc_o, stall_ifid_o,
    output flush_ifid_o,
    output stall_idex_o, flush_idex_o
  );

endinterface

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter for perf statistics.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] q
);

  // count up on inc until all-ones
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and flow-control unit for the 5-stage core.
// Drives pc_reg/if_id/id_ex hold and flush controls.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES      = 1,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 32
) (
  input  logic             clk,
  input  logic             rst,
  pipeline_ctrl_if.slave   bus,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam logic [2:0] FL_LOAD =
    3'(FLUSH_CYCLES - 1);
  localparam logic [2:0] LS_LOAD =
    3'(LOAD_STALL_CYCLES - 1);

  logic [1:0] state, state_n;
  logic [2:0] cnt, cnt_n;
  logic       haz;
  logic       hit1, hit2;
  logic       sel_jmp, sel_frz;
  logic       sel_ls, sel_fl, sel_haz;
  ctrl_t      ctl;

  // load-use match against id_ex destination
  always_comb begin
    hit1 = bus.id_rs1_used_i &&
           (bus.id_rs1_addr_i == bus.idex_rd_addr_i);
    hit2 = bus.id_rs2_used_i &&
           (bus.id_rs2_addr_i == bus.idex_rd_addr_i);
    haz  = bus.idex_is_load_i && bus.idex_reg_wen_i &&
           (bus.idex_rd_addr_i != 5'd0) && (hit1 || hit2);
  end

  // one-hot priority: jump > freeze > tails > haz
  always_comb begin
    sel_jmp = bus.jump_en_i;
    sel_frz = !sel_jmp &&
              (bus.ex_busy_i || bus.ext_hold_i);
    sel_ls  = !sel_jmp && !sel_frz &&
              (state == ST_LSTALL);
    sel_fl  = !sel_jmp && !sel_frz &&
              (state == ST_FLUSH);
    sel_haz = !sel_jmp && !sel_frz &&
              (state == ST_RUN) && haz;
  end

  // control decode and next-state
  always_comb begin
    ctl     = CTRL_NONE;
    state_n = state;
    cnt_n   = cnt;
    if (rst) begin
      unique case (1'b1)
        sel_jmp: begin
          ctl.jump_en    = 1'b1;
          ctl.flush_ifid = 1'b1;
          ctl.flush_idex = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_n = ST_FLUSH;
            cnt_n   = FL_LOAD;
          end else begin
            state_n = ST_RUN;
            cnt_n   = 3'd0;
          end
        end
        sel_frz: begin
          ctl.stall_pc   = 1'b1;
          ctl.stall_ifid = 1'b1;
          ctl.stall_idex = 1'b1;
        end
        sel_ls: begin
          ctl.stall_pc   = 1'b1;
          ctl.stall_ifid = 1'b1;
          ctl.flush_idex = 1'b1;
          cnt_n = cnt - 3'd1;
          if (cnt <= 3'd1) begin
            state_n = ST_RUN;
            cnt_n   = 3'd0;
          end
        end
        sel_fl: begin
          ctl.flush_ifid = 1'b1;
          cnt_n = cnt - 3'd1;
          if (cnt <= 3'd1) begin
            state_n = ST_RUN;
            cnt_n   = 3'd0;
          end
        end
        sel_haz: begin
          ctl.stall_pc   = 1'b1;
          ctl.stall_ifid = 1'b1;
          ctl.flush_idex = 1'b1;
          if (LOAD_STALL_CYCLES > 1) begin
            state_n = ST_LSTALL;
            cnt_n   = LS_LOAD;
          end
        end
        default: begin
          state_n = ST_RUN;
          cnt_n   = 3'd0;
        end
      endcase
    end
  end

  // state and down-counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_RUN;
      cnt   <= 3'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // drive stage controls onto the bus
  always_comb begin
    bus.jump_en_o    = ctl.jump_en;
    bus.jump_addr_o  = ctl.jump_en ?
                       bus.jump_addr_i : 32'd0;
    bus.stall_pc_o   = ctl.stall_pc;
    bus.stall_ifid_o = ctl.stall_ifid;
    bus.flush_ifid_o = ctl.flush_ifid;
    bus.stall_idex_o = ctl.stall_idex;
    bus.flush_idex_o = ctl.flush_idex;
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (any_stall(ctl)),
    .q   (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (ctl.jump_en),
    .q   (flush_cnt_o)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed scoreboard bench for pipeline_ctrl.
// FLUSH_CYCLES=3, LOAD_STALL_CYCLES=2, CNT_W=4.
module tb_pipeline_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [3:0] stall_cnt, flush_cnt;

  pipeline_ctrl_if bus ();

  pipeline_ctrl #(
    .FLUSH_CYCLES      (3),
    .LOAD_STALL_CYCLES (2),
    .CNT_W             (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .stall_cnt_o (stall_cnt),
    .flush_cnt_o (flush_cnt)
  );

  always #5 clk = ~clk;

  // {jump_en, stall_pc, stall_ifid, stall_idex,
  //  flush_ifid, flush_idex}
  localparam logic [5:0] C_NONE = 6'b000000;
  localparam logic [5:0] C_JMP  = 6'b100011;
  localparam logic [5:0] C_FL   = 6'b000010;
  localparam logic [5:0] C_BUB  = 6'b011001;
  localparam logic [5:0] C_FRZ  = 6'b011100;

  typedef struct packed {
    logic [5:0]  ctl;
    logic [31:0] addr;
    logic [3:0]  sc;
    logic [3:0]  fc;
  } exp_t;

  exp_t  q[$];
  string nq[$];
  int    checks = 0;
  int    failures = 0;
  bit    done = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.jump_en_i      = 1'b0;
    bus.jump_addr_i    = 32'd0;
    bus.ex_busy_i      = 1'b0;
    bus.ext_hold_i     = 1'b0;
    bus.idex_is_load_i = 1'b0;
    bus.idex_reg_wen_i = 1'b0;
    bus.idex_rd_addr_i = 5'd0;
    bus.id_rs1_addr_i  = 5'd0;
    bus.id_rs2_addr_i  = 5'd0;
    bus.id_rs1_used_i  = 1'b0;
    bus.id_rs2_used_i  = 1'b0;
  endtask

  task automatic load(input logic [4:0] rd,
                      input logic [4:0] r1,
                      input logic u1,
                      input logic [4:0] r2,
                      input logic u2);
    bus.idex_is_load_i = 1'b1;
    bus.idex_reg_wen_i = 1'b1;
    bus.idex_rd_addr_i = rd;
    bus.id_rs1_addr_i  = r1;
    bus.id_rs1_used_i  = u1;
    bus.id_rs2_addr_i  = r2;
    bus.id_rs2_used_i  = u2;
  endtask

  task automatic expect_out(input string nm,
                            input logic [5:0] c,
                            input logic [31:0] a,
                            input logic [3:0] sc,
                            input logic [3:0] fc);
    exp_t e;
    e.ctl  = c;
    e.addr = a;
    e.sc   = sc;
    e.fc   = fc;
    q.push_back(e);
    nq.push_back(nm);
  endtask

  // monitor: compare every cycle's outputs
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t  e;
      string nm;
      logic [5:0] act;
      e  = q.pop_front();
      nm = nq.pop_front();
      act = {bus.jump_en_o, bus.stall_pc_o,
             bus.stall_ifid_o, bus.stall_idex_o,
             bus.flush_ifid_o, bus.flush_idex_o};
      checks++;
      if (act !== e.ctl || bus.jump_addr_o !== e.addr) begin
        failures++;
        $display("FAIL %s ctl: got %b addr %h, want %b addr %h",
                 nm, act, bus.jump_addr_o, e.ctl, e.addr);
      end
      checks++;
      if (stall_cnt !== e.sc || flush_cnt !== e.fc) begin
        failures++;
        $display("FAIL %s cnt: got sc=%0d fc=%0d, want sc=%0d fc=%0d",
                 nm, stall_cnt, flush_cnt, e.sc, e.fc);
      end
    end
  end

  initial begin
    idle();
    // reset held: jump request must not show
    tick();
    bus.jump_en_i   = 1'b1;
    bus.jump_addr_i = 32'h80;
    expect_out("rst_a", C_NONE, 32'h0, 4'd0, 4'd0);
    tick();
    expect_out("rst_b", C_NONE, 32'h0, 4'd0, 4'd0);
    // release: jump passes through
    tick();
    rst = 1'b1;
    expect_out("jmp0", C_JMP, 32'h80, 4'd0, 4'd0);
    tick();
    idle();
    expect_out("jmp1", C_FL, 32'h0, 4'd0, 4'd1);
    tick();
    expect_out("jmp2", C_FL, 32'h0, 4'd0, 4'd1);
    tick();
    expect_out("jmp3", C_NONE, 32'h0, 4'd0, 4'd1);
    // load-use on rs2
    tick();
    load(5'd5, 5'd1, 1'b1, 5'd5, 1'b1);
    expect_out("lu0", C_BUB, 32'h0, 4'd0, 4'd1);
    tick();
    idle();
    expect_out("lu1", C_BUB, 32'h0, 4'd1, 4'd1);
    tick();
    expect_out("lu2", C_NONE, 32'h0, 4'd2, 4'd1);
    // rd=x0 never hazards
    tick();
    load(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
    expect_out("rd0", C_NONE, 32'h0, 4'd2, 4'd1);
    // no reg write, no hazard
    tick();
    load(5'd7, 5'd7, 1'b1, 5'd0, 1'b0);
    bus.idex_reg_wen_i = 1'b0;
    expect_out("nowen", C_NONE, 32'h0, 4'd2, 4'd1);
    // busy freezes LSTALL tail
    tick();
    load(5'd3, 5'd3, 1'b1, 5'd9, 1'b0);
    expect_out("bz_haz", C_BUB, 32'h0, 4'd2, 4'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      idle();
      bus.ex_busy_i = 1'b1;
      expect_out("bz_frz", C_FRZ, 32'h0,
                 4'(3 + i), 4'd1);
    end
    tick();
    idle();
    expect_out("bz_tail", C_BUB, 32'h0, 4'd7, 4'd1);
    tick();
    expect_out("bz_run", C_NONE, 32'h0, 4'd8, 4'd1);
    // jump aborts LSTALL
    tick();
    load(5'd4, 5'd4, 1'b1, 5'd0, 1'b0);
    expect_out("ja_haz", C_BUB, 32'h0, 4'd8, 4'd1);
    tick();
    bus.jump_en_i   = 1'b1;
    bus.jump_addr_i = 32'h100;
    expect_out("ja_jmp", C_JMP, 32'h100, 4'd9, 4'd1);
    tick();
    bus.jump_en_i   = 1'b0;
    bus.jump_addr_i = 32'h0;
    expect_out("ja_fl", C_FL, 32'h0, 4'd9, 4'd2);
    // jump in FLUSH reloads cnt
    tick();
    idle();
    bus.jump_en_i   = 1'b1;
    bus.jump_addr_i = 32'h200;
    expect_out("jf_jmp", C_JMP, 32'h200, 4'd9, 4'd2);
    tick();
    idle();
    bus.ext_hold_i = 1'b1;
    expect_out("jf_hold", C_FRZ, 32'h0, 4'd9, 4'd3);
    tick();
    idle();
    expect_out("jf_fl1", C_FL, 32'h0, 4'd10, 4'd3);
    tick();
    expect_out("jf_fl2", C_FL, 32'h0, 4'd10, 4'd3);
    tick();
    expect_out("jf_run", C_NONE, 32'h0, 4'd10, 4'd3);
    // jump beats ex_busy
    tick();
    bus.jump_en_i   = 1'b1;
    bus.ex_busy_i   = 1'b1;
    bus.jump_addr_i = 32'h44;
    expect_out("jb_jmp", C_JMP, 32'h44, 4'd10, 4'd3);
    tick();
    idle();
    expect_out("jb_fl1", C_FL, 32'h0, 4'd10, 4'd4);
    tick();
    expect_out("jb_fl2", C_FL, 32'h0, 4'd10, 4'd4);
    // 20 frozen cycles saturate stall_cnt
    for (int i = 0; i < 20; i++) begin
      tick();
      bus.ex_busy_i = 1'b1;
      expect_out("sat", C_FRZ, 32'h0,
                 (i < 5) ? 4'(10 + i) : 4'hF, 4'd4);
    end
    tick();
    idle();
    expect_out("sat_end", C_NONE, 32'h0, 4'hF, 4'd4);
    tick();
    done = 1'b1;
  end

  initial begin
    int guard;
    guard = 0;
    while (!done && guard < 2000) begin
      @(posedge clk);
      guard++;
    end
    repeat (2) @(posedge clk);
    if (!done || q.size() != 0) begin
      failures++;
      $display("FAIL timeout: pending=%0d done=%0d, want 0 and 1",
               q.size(), done);
    end
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central hazard/flow-control unit for the 5-stage core; it generates the per-stage hold/flush controls that the pipeline registers (pc_reg, if_id, id_ex) consume.
- Resolves three conditions: EX-stage jump redirects (flush), load-use hazards against the instruction in id_ex (bubble), and multi-cycle EX ops or external holds (freeze).
- Keeps saturating stall/flush performance counters.

Parameters:
- FLUSH_CYCLES, 1: cycles if_id stays flushed after a jump (1..7); covers fetch-memory latency.
- LOAD_STALL_CYCLES, 1: bubble cycles per load-use hazard (1..7).
- CNT_W, 32: width of each performance counter.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-low reset.
- jump_en_i  in  1  EX resolved a taken branch/jump this cycle.
- jump_addr_i  in  32  redirect target.
- ex_busy_i  in  1  EX holds a multi-cycle op (mul/div) not yet complete.
- ext_hold_i  in  1  external hold (bus wait/debug).
- idex_is_load_i  in  1  instruction currently in id_ex is a load.
- idex_reg_wen_i  in  1  id_ex reg_wen.
- idex_rd_addr_i  in  5  id_ex rd_addr.
- id_rs1_addr_i  in  5  ID-stage rs1.
- id_rs2_addr_i  in  5  ID-stage rs2.
- id_rs1_used_i  in  1  ID instruction reads rs1.
- id_rs2_used_i  in  1  ID instruction reads rs2.
- jump_en_o  out  1  to pc_reg: load jump_addr_o.
- jump_addr_o  out  32  redirect target.
- stall_pc_o  out  1  pc_reg keeps its value.
- stall_ifid_o  out  1  if_id keeps its value.
- flush_ifid_o  out  1  if_id loads INST_NOP/zeros.
- stall_idex_o  out  1  id_ex keeps its value.
- flush_idex_o  out  1  id_ex loads INST_NOP/zeros.
- stall_cnt_o  out  CNT_W  cycles with any stall_* asserted.
- flush_cnt_o  out  CNT_W  jumps taken.

Behaviour:
- States: RUN, FLUSH, LSTALL. Down-counter cnt is 3 bits. Registered elements: state, cnt, both perf counters. All other outputs are combinational from the inputs and state.
- Reset (rst=0, asynchronous): state=RUN, cnt=0, counters=0. All outputs are forced to 0 while rst=0, regardless of inputs.
- Hazard: haz = idex_is_load_i & idex_reg_wen_i & (idex_rd_addr_i!=0) & ((id_rs1_used_i & rs1==rd) | (id_rs2_used_i & rs2==rd)).
- Priority per cycle: jump > ex_busy > ext_hold > LSTALL/haz > FLUSH tail > RUN.
- Jump (any state):
  - Same cycle: jump_en_o=1, jump_addr_o=jump_addr_i, flush_ifid_o=1, flush_idex_o=1, all stall_*=0.
  - If FLUSH_CYCLES>1: next state FLUSH with cnt=FLUSH_CYCLES-1; otherwise next state RUN.
  - A jump during FLUSH restarts cnt. A jump during LSTALL aborts the stall.
  - flush_cnt_o increments by 1, saturating at all-ones.
- ex_busy_i or ext_hold_i (no jump):
  - stall_pc_o, stall_ifid_o, stall_idex_o = 1; no flush.
  - state and cnt are frozen; a pending FLUSH or LSTALL tail resumes afterwards.
- RUN with haz:
  - stall_pc_o=1, stall_ifid_o=1, flush_idex_o=1 (bubble).
  - If LOAD_STALL_CYCLES>1: next state LSTALL with cnt=LOAD_STALL_CYCLES-1.
- LSTALL (no jump/busy/hold):
  - Same outputs as haz, independent of haz (id_ex already holds a NOP).
  - cnt decrements each cycle; when cnt==1, next state RUN.
- FLUSH (no jump/busy/hold):
  - flush_ifid_o=1 only; cnt decrements; when cnt==1, next state RUN.
  - haz is ignored in FLUSH because id_ex holds a NOP.
- jump_addr_o = 0 whenever jump_en_o=0.
- stall_cnt_o increments in every cycle with any stall_* high, saturating.
- stall_X and flush_X for the same register are never both 1.

Decomposition:
- Shared defines: state encodings (RUN=2'd0, FLUSH=2'd1, LSTALL=2'd2) and INST_NOP, taken from the existing defines.v.
- One sub-module, sat_counter (parameterised width, inc input, async active-low clear), instantiated twice for the perf counters.

Test Plan:
- Reset: drive jump_en_i=1 with rst=0 -> all outputs 0. Release rst -> jump_en_o follows jump_en_i; counters are 0.
- Jump, FLUSH_CYCLES=3, jump_addr_i=32'h80 for one cycle -> cycle0: jump_en_o=1, jump_addr_o=32'h80, both flushes high; cycles 1-2: flush_ifid_o only; cycle 3: all low; flush_cnt_o=1.
- Load-use: idex load, rd=5, id rs2=5 used, LOAD_STALL_CYCLES=2 -> two cycles of stall_pc/stall_ifid/flush_idex, then RUN; stall_cnt_o=2. The same case with rd=0 -> no stall.
- ex_busy_i high 4 cycles during an LSTALL with cnt=1 -> 4 cycles of all three stalls, then 1 bubble cycle; stall_cnt_o +5.
- Jump arriving in LSTALL -> same-cycle jump outputs, no stall, LSTALL abandoned. Jump during FLUSH -> cnt reloaded.
- Saturation, CNT_W=4: 20 stall cycles -> stall_cnt_o holds 4'hF.
